// File: rtl/ui_input_conditioner_if.sv
// Bundle of the board-input and UI-controller signals around the input conditioner.
// slave is the conditioner's view; master is the view of whoever drives the raw inputs.
interface ui_input_conditioner_if #(
  parameter int DBITS = 32,
  parameter int NKEYS = 4,
  parameter int NSW   = 10
);
  logic [NKEYS-1:0] KEY;
  logic [NSW-1:0]   SW;
  logic             clrEn;
  logic [NKEYS-1:0] clrMask;
  logic [NKEYS-1:0] keyState;
  logic [NKEYS-1:0] keyPressed;
  logic [NSW-1:0]   swState;
  logic [DBITS-1:0] keyData;
  logic [DBITS-1:0] swData;

  modport slave (
    input  KEY, SW, clrEn, clrMask,
    output keyState, keyPressed, swState, keyData, swData
  );

  modport master (
    output KEY, SW, clrEn, clrMask,
    input  keyState, keyPressed, swState, keyData, swData
  );
endinterface

// File: rtl/ui_input_conditioner.sv
// Synchronizes and debounces raw KEY/SW inputs and keeps sticky key-press flags
// that the UI controller reads as keyData/swData and clears with clrEn/clrMask.
module ui_input_conditioner #(
  parameter int DBITS           = 32,
  parameter int NKEYS           = 4,
  parameter int NSW             = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = 20
) (
  input logic                   clk,
  input logic                   reset,
  ui_input_conditioner_if.slave bus
);

  localparam int NBITS = NKEYS + NSW;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } dbState_t;

  // Keys occupy the low NKEYS positions, switches sit above them.
  logic [NBITS-1:0] syncBits;
  logic [NBITS-1:0] stableBits;
  logic [NKEYS-1:0] riseBits;
  logic [NKEYS-1:0] pressedBits;

  genvar gi;

  // Key synchronizers idle at 1 (released) and are inverted to active-high.
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_keySync
      logic metaReg;
      logic syncReg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          metaReg <= 1'b1;
          syncReg <= 1'b1;
        end else begin
          metaReg <= bus.KEY[gi];
          syncReg <= metaReg;
        end
      end

      assign syncBits[gi] = ~syncReg;
    end
  endgenerate

  generate
    for (gi = 0; gi < NSW; gi++) begin : g_swSync
      logic metaReg;
      logic syncReg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          metaReg <= 1'b0;
          syncReg <= 1'b0;
        end else begin
          metaReg <= bus.SW[gi];
          syncReg <= metaReg;
        end
      end

      assign syncBits[NKEYS+gi] = syncReg;
    end
  endgenerate

  // One independent debouncer per bit. The counter only runs in CHANGING and is
  // cleared on acceptance, so it can never pass CNT_LAST.
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_debounce
      dbState_t            stateReg;
      logic [CNT_BITS-1:0] cntReg;
      logic                stableReg;
      logic                differs;
      logic                accept;

      assign differs = (syncBits[gi] != stableReg);
      assign accept  = (stateReg == CHANGING) && differs && (cntReg == CNT_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stateReg  <= STABLE;
          cntReg    <= '0;
          stableReg <= 1'b0;
        end else begin
          case (stateReg)
            STABLE: begin
              if (differs) begin
                stateReg <= CHANGING;
                cntReg   <= CNT_ONE;
              end else begin
                cntReg   <= '0;
              end
            end
            CHANGING: begin
              if (!differs) begin
                stateReg <= STABLE;
                cntReg   <= '0;
              end else if (cntReg == CNT_LAST) begin
                stateReg  <= STABLE;
                cntReg    <= '0;
                stableReg <= syncBits[gi];
              end else begin
                cntReg   <= cntReg + CNT_ONE;
              end
            end
            default: begin
              stateReg <= STABLE;
              cntReg   <= '0;
            end
          endcase
        end
      end

      assign stableBits[gi] = stableReg;

      if (gi < NKEYS) begin : g_rise
        assign riseBits[gi] = accept & syncBits[gi];
      end
    end
  endgenerate

  // Press flags: a rising accept in the same cycle as a clear keeps the flag set.
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_press
      logic pressedReg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pressedReg <= 1'b0;
        end else if (riseBits[gi]) begin
          pressedReg <= 1'b1;
        end else if (bus.clrEn && bus.clrMask[gi]) begin
          pressedReg <= 1'b0;
        end
      end

      assign pressedBits[gi] = pressedReg;
    end
  endgenerate

  assign bus.keyState   = stableBits[NKEYS-1:0];
  assign bus.swState    = stableBits[NBITS-1:NKEYS];
  assign bus.keyPressed = pressedBits;
  assign bus.keyData    = {{(DBITS-2*NKEYS){1'b0}}, pressedBits, stableBits[NKEYS-1:0]};
  assign bus.swData     = {{(DBITS-NSW){1'b0}}, stableBits[NBITS-1:NKEYS]};

endmodule

// File: doc/ui_input_conditioner.md
# ui_input_conditioner

Synchronizes and debounces the raw board KEY and SW inputs and records key-press events, so the UI controller always reads clean, glitch-free values. It sits directly upstream of the UI controller on the memory-mapped KEY (0xF0000010) and SW (0xF0000014) path. The UI controller samples `keyData` and `swData` and pulses `clrEn` when software acknowledges key presses.

## Interface
Parameters:
- `DBITS`, 32, width of the `keyData` and `swData` read words.
- `NKEYS`, 4, number of push-buttons.
- `NSW`, 10, number of slide switches.
- `DEBOUNCE_CYCLES`, 500000, number of consecutive stable synchronized samples required before a level change is accepted. Must be ≥ 2.
- `CNT_BITS`, 20, debounce counter width. Must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk`  in  1  system clock (PLL output).
- `reset`  in  1  asynchronous, active-high reset.
- `KEY`  in  NKEYS  raw push-buttons, active-low (0 = pressed), asynchronous to `clk`.
- `SW`  in  NSW  raw slide switches, active-high, asynchronous to `clk`.
- `clrEn`  in  1  one-cycle strobe from the UI controller that clears press flags.
- `clrMask`  in  NKEYS  flags to clear when `clrEn`=1 (bit i clears `keyPressed[i]`).
- `keyState`  out  NKEYS  debounced key level, active-high (1 = held).
- `keyPressed`  out  NKEYS  sticky press-event flags.
- `swState`  out  NSW  debounced switch levels.
- `keyData`  out  DBITS  `{zeros, keyPressed, keyState}`: `keyState` in bits [NKEYS-1:0], `keyPressed` in bits [2*NKEYS-1:NKEYS].
- `swData`  out  DBITS  `{zeros, swState}`.

## Operation
- **Synchronizer.** Each input bit passes through a 2-flop synchronizer. KEY bits are inverted after the second flop, so all internal logic is active-high.
- **Debounce.** Each of the NKEYS+NSW bits has an independent counter and stable register, and behaves as a 2-state machine: STABLE and CHANGING.
  - STABLE: synchronized value equals the stable register; counter is 0.
  - STABLE → CHANGING: synchronized value differs from the stable register; counter increments.
  - CHANGING → STABLE (bounce): synchronized value returns to the stable value; counter is cleared to 0 and the stable value is unchanged.
  - CHANGING → STABLE (accept): counter reaches `DEBOUNCE_CYCLES-1` while the value still differs; the stable register takes the new value and the counter is cleared.
- **Press flag.** `keyPressed[i]` is set in the same clock edge that `keyState[i]` goes 0→1. It stays set until cleared. Release (1→0) never sets or clears a flag.
- **Clear.** On `clrEn`=1, bits with `clrMask`=1 are cleared. If a set and a clear hit the same bit in the same cycle, set wins. `clrEn`=0 ignores `clrMask`.
- All outputs are direct register outputs; `keyData` and `swData` are pure wiring of those registers.

## Timing
- **Reset values:**
  - KEY synchronizer flops = 1 (released); SW synchronizer flops = 0.
  - Counters = 0.
  - `keyState`, `keyPressed`, `swState` = 0; `keyData` and `swData` = 0.
- **Reset mid-debounce:** the partial count is discarded. After deassertion, a held key needs a full 2 + `DEBOUNCE_CYCLES` cycles to register.
- **Latency:** a clean input change appears on the state output 2 + `DEBOUNCE_CYCLES` rising edges after it is first sampled. `keyPressed` rises on the same edge as `keyState`.
- **Bounce handling:** any reversion before the count completes restarts the full `DEBOUNCE_CYCLES` window.
- **Clear timing:** a flag cleared by `clrEn` in cycle n reads 0 in cycle n+1.
- **Counter wrap:** the counter saturates by construction, because it clears at `DEBOUNCE_CYCLES-1`. It never wraps.
- **Bit independence:** bits are fully independent. Simultaneous changes on several bits are each debounced separately.
- **Outputs:** no combinational path from any input to any output.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.

1. **Reset.** Assert `reset` with KEY=4'hF, SW=10'h3FF → all outputs 0 while reset is held. Release reset → `swState`=10'h3FF exactly 6 cycles later and `keyState`=0 throughout.
2. **Clean press.** Drive KEY[2]: 1→0 and hold → `keyState`=4'b0100 and `keyPressed`=4'b0100 on edge 6 after the change. `keyData`=32'h44.
3. **Bounce.** Toggle KEY[0] 0,1,0,1 one cycle each, then hold 0 → no output change until 6 cycles after the final transition. Exactly one press flag is set.
4. **Clear with mask.** With `keyPressed`=4'b0101, pulse `clrEn`=1 and `clrMask`=4'b0001 → next cycle `keyPressed`=4'b0100 and `keyState` is unchanged.
5. **Set/clear collision.** Pulse `clrEn` with `clrMask`=4'b1000 on the exact edge where `keyState[3]` goes 0→1 → `keyPressed[3]`=1. Release KEY[3] → flag stays 1 after `keyState[3]` returns to 0.
6. **Reset mid-debounce.** Change SW[5] 0→1 and assert `reset` after 3 cycles → `swState[5]`=0 after reset. After deassertion, it rises 6 cycles later.
